// File: rtl/fir_out_stage.sv
// Output stage for fir_main: rounding right-shift, saturation to OUT_W bits, a small
// show-ahead FIFO on a valid/ready port, and sticky overflow/saturation flags.
module fir_out_stage #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_W-1:0]          s_axis_fir_tdata,
  input  logic                     s_axis_fir_tvalid,
  input  logic [1:0]               shift,
  output logic [OUT_W-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     clr_flags,
  output logic                     ovf,
  output logic                     sat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int          SatMax = (1 << (OUT_W - 1)) - 1;
  localparam int          SatMin = -(1 << (OUT_W - 1));

  // Stage 1: scale and clip
  logic        [IN_W:0]  rnd_add;
  logic signed [IN_W:0]  ext;
  logic signed [IN_W:0]  rounded;
  logic signed [IN_W:0]  scaled;
  logic        [OUT_W-1:0] clipped;
  logic                  clip;

  always_comb begin
    rnd_add    = '0;
    rnd_add[0] = (shift == 2'd1);
    rnd_add[1] = (shift == 2'd2);
    rnd_add[2] = (shift == 2'd3);
    // One extra bit keeps the rounding add from wrapping at the positive full-scale value.
    ext        = {s_axis_fir_tdata[IN_W-1], s_axis_fir_tdata};
    rounded    = ext + rnd_add;
    scaled     = rounded >>> shift;
    clip       = 1'b0;
    clipped    = scaled[OUT_W-1:0];
    if (int'(scaled) > SatMax) begin
      clipped = OUT_W'(SatMax);
      clip    = 1'b1;
    end else if (int'(scaled) < SatMin) begin
      clipped = OUT_W'(SatMin);
      clip    = 1'b1;
    end
  end

  logic             pipe_valid_q;
  logic             pipe_sat_q;
  logic [OUT_W-1:0] pipe_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= 1'b0;
      pipe_sat_q   <= 1'b0;
      pipe_data_q  <= '0;
    end else begin
      pipe_valid_q <= s_axis_fir_tvalid;
      if (s_axis_fir_tvalid) begin
        pipe_sat_q  <= clip;
        pipe_data_q <= clipped;
      end
    end
  end

  // Stage 2: FIFO
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             not_empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ovf_q;
  logic             sat_q;

  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty && m_axis_tready;
    // A full FIFO still accepts when the head leaves on the same edge.
    push      = pipe_valid_q && ((count_q < CntW'(DEPTH)) || pop);
    drop      = pipe_valid_q && !push;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pipe_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Set beats clear when both happen on the same edge.
      ovf_q <= drop || (ovf_q && !clr_flags);
      sat_q <= (pipe_valid_q && pipe_sat_q) || (sat_q && !clr_flags);
    end
  end

  always_comb begin
    m_axis_tvalid = not_empty;
    m_axis_tdata  = not_empty ? mem_q[rd_ptr_q] : '0;
    level         = count_q;
    ovf           = ovf_q;
    sat           = sat_q;
  end

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_fir_out_stage;

  localparam int IN_W  = 11;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [IN_W-1:0]       s_axis_fir_tdata = '0;
  logic                  s_axis_fir_tvalid = 1'b0;
  logic [1:0]            shift = '0;
  logic [OUT_W-1:0]      m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b0;
  logic                  clr_flags = 1'b0;
  logic                  ovf;
  logic                  sat;
  logic [$clog2(DEPTH):0] level;

  fir_out_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_fir_tdata  (s_axis_fir_tdata),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .shift             (shift),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .clr_flags         (clr_flags),
    .ovf               (ovf),
    .sat               (sat),
    .level             (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: one in-flight scaled sample plus a queue of buffered results.
  bit m_pv;
  int m_pd;
  bit m_ps;
  int mq[$];
  bit m_ovf;
  bit m_sat;
  int pops[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Round half up, floor-divide by 2^sh, clip to the signed output range.
  function automatic int scale(input int d, input int sh, output bit clipped);
    int v;
    int div;
    int q;
    v   = d + ((sh > 0) ? (1 << (sh - 1)) : 0);
    div = 1 << sh;
    q   = v / div;
    if (v < 0 && q * div != v) q = q - 1;
    clipped = 1'b0;
    if (q > 127) begin
      q = 127;
      clipped = 1'b1;
    end else if (q < -128) begin
      q = -128;
      clipped = 1'b1;
    end
    return q;
  endfunction

  task automatic model_step(input bit v, input int d, input int sh, input bit rdy,
                            input bit clr, input bit rst);
    bit pop;
    bit drop;
    bit c;
    if (rst) begin
      m_pv = 0; mq.delete(); m_ovf = 0; m_sat = 0;
      return;
    end
    pop  = (mq.size() > 0) && rdy;
    drop = m_pv && (mq.size() == DEPTH) && !pop;
    m_ovf = drop || (m_ovf && !clr);
    m_sat = (m_pv && m_ps) || (m_sat && !clr);
    if (pop) void'(mq.pop_front());
    if (m_pv && !drop) mq.push_back(m_pd);
    m_pv = v;
    if (v) begin
      m_pd = scale(d, sh, c);
      m_ps = c;
    end
  endtask

  task automatic compare();
    chk("tvalid", int'(m_axis_tvalid), (mq.size() > 0) ? 1 : 0);
    chk("tdata", int'($signed(m_axis_tdata)), (mq.size() > 0) ? mq[0] : 0);
    chk("level", int'(level), mq.size());
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("sat", int'(sat), int'(m_sat));
  endtask

  task automatic cyc(input bit v, input int d, input int sh, input bit rdy,
                     input bit clr, input bit rst);
    s_axis_fir_tvalid = v;
    s_axis_fir_tdata  = IN_W'(d);
    shift             = 2'(sh);
    m_axis_tready     = rdy;
    clr_flags         = clr;
    reset             = rst;
    @(negedge clk);
    if (m_axis_tvalid && m_axis_tready) pops.push_back(int'($signed(m_axis_tdata)));
    @(posedge clk);
    model_step(v, d, sh, rdy, clr, rst);
    #1;
    compare();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, 0, 0);
  endtask

  task automatic chk_pops(input string name, input int n, input int exp[8]);
    chk({name, "_count"}, pops.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_pop%0d", name, i), (i < pops.size()) ? pops[i] : 9999, exp[i]);
    end
    pops.delete();
  endtask

  initial begin
    int e[8];
    bit c;

    // Pin the model's scaling rule with hand-computed values.
    chk("model_301_s2", scale(301, 2, c), 75);
    chk("model_m6_s2", scale(-6, 2, c), -1);
    chk("model_m2_s2", scale(-2, 2, c), 0);
    chk("model_1023_s3", scale(1023, 3, c), 127);
    chk("model_1023_s3_clip", int'(c), 1);
    chk("model_m300_s0", scale(-300, 0, c), -128);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_level", int'(level), 0);
    pops.delete();

    // 1: shift 0 saturation, 2-cycle latency
    cyc(1, 100, 0, 1, 0, 0);
    chk("s1_lat0", int'(m_axis_tvalid), 0);
    cyc(1, 300, 0, 1, 0, 0);
    chk("s1_lat1", int'(m_axis_tvalid), 1);
    chk("s1_first", int'($signed(m_axis_tdata)), 100);
    cyc(1, -300, 0, 1, 0, 0);
    cyc(1, -128, 0, 1, 0, 0);
    idle(4, 1);
    chk("s1_sat", int'(sat), 1);
    e = '{100, 127, -128, -128, 0, 0, 0, 0};
    chk_pops("s1", 4, e);

    // 2: shift 2 rounding, then shift 3 clip
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 301, 2, 1, 0, 0);
    cyc(1, -6, 2, 1, 0, 0);
    cyc(1, 2, 2, 1, 0, 0);
    cyc(1, -2, 2, 1, 0, 0);
    idle(3, 1);
    chk("s2_nosat", int'(sat), 0);
    e = '{75, -1, 1, 0, 0, 0, 0, 0};
    chk_pops("s2a", 4, e);
    cyc(1, 1023, 3, 1, 0, 0);
    idle(3, 1);
    chk("s2_sat", int'(sat), 1);
    e = '{127, 0, 0, 0, 0, 0, 0, 0};
    chk_pops("s2b", 1, e);

    // 3: overflow with stalled consumer
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 6; i++) cyc(1, i, 0, 0, 0, 0);
    idle(2, 0);
    chk("s3_full", int'(level), 4);
    chk("s3_ovf", int'(ovf), 1);
    idle(6, 1);
    chk("s3_empty", int'(level), 0);
    e = '{1, 2, 3, 4, 0, 0, 0, 0};
    chk_pops("s3", 4, e);

    // 5a: clear flags
    cyc(0, 0, 0, 1, 1, 0);
    chk("s5_ovf_clr", int'(ovf), 0);
    chk("s5_sat_clr", int'(sat), 0);

    // 4: full FIFO with pop and push on the same edge
    for (int i = 11; i <= 14; i++) cyc(1, i, 0, 0, 0, 0);
    cyc(1, 15, 0, 0, 0, 0);
    chk("s4_full", int'(level), 4);
    cyc(0, 0, 0, 1, 0, 0);
    chk("s4_level", int'(level), 4);
    chk("s4_noovf", int'(ovf), 0);
    idle(6, 1);
    e = '{11, 12, 13, 14, 15, 0, 0, 0};
    chk_pops("s4", 5, e);

    // 5b: clear on the same edge as a new overflow
    for (int i = 1; i <= 5; i++) cyc(1, i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s5_set_wins", int'(ovf), 1);

    // 6: reset with 3 queued and one in flight
    cyc(1, 7, 0, 1, 0, 0);
    chk("s6_level3", int'(level), 3);
    cyc(1, 99, 0, 1, 1, 1);
    chk("s6_tvalid", int'(m_axis_tvalid), 0);
    chk("s6_tdata", int'(m_axis_tdata), 0);
    chk("s6_level", int'(level), 0);
    chk("s6_ovf", int'(ovf), 0);
    chk("s6_sat", int'(sat), 0);
    pops.delete();
    cyc(1, 42, 0, 1, 0, 0);
    chk("s6_lat0", int'(m_axis_tvalid), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("s6_lat1", int'(m_axis_tvalid), 1);
    chk("s6_data", int'($signed(m_axis_tdata)), 42);
    idle(3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
